// File: rtl/rc_pwm_demodulator_array_if.sv
// Bus bundle for the RC PWM demodulator array: global enable, raw PWM pins and
// the per-channel status/level outputs plus the registered active-channel count.
interface rc_pwm_demodulator_array_if #(
    parameter int CHANNELS = 8
);
    localparam int OW = $clog2(CHANNELS + 1);

    logic                enable_i;
    logic [CHANNELS-1:0] pwm_i;
    logic [CHANNELS-1:0] channel_o;
    logic [CHANNELS-1:0] pulse_valid_o;
    logic [CHANNELS-1:0] pulse_error_o;
    logic [CHANNELS-1:0] signal_lost_o;
    logic [OW-1:0]       ones_o;

    modport master (
        output enable_i, pwm_i,
        input  channel_o, pulse_valid_o, pulse_error_o, signal_lost_o, ones_o
    );

    modport slave (
        input  enable_i, pwm_i,
        output channel_o, pulse_valid_o, pulse_error_o, signal_lost_o, ones_o
    );
endinterface

// File: rtl/rc_pwm_demodulator_array.sv
// N-channel RC servo PWM demodulator: pulse-width measurement, hysteresis on/off,
// glitch/stuck-high errors. Define FAILSAFE_EN to add the per-channel signal-loss timeout.
module rc_pwm_channel #(
    parameter int MAX_COUNTER_VALUE  = 2500,
    parameter int HIGH_COUNTER_VALUE = 1800,
    parameter int LOW_COUNTER_VALUE  = 1200,
    parameter int MIN_PULSE_VALUE    = 500,
    parameter int TIMEOUT_VALUE      = 25000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_pwm,
    output logic o_chan,
    output logic o_valid,
    output logic o_error,
    output logic o_lost
);
    localparam int CW = $clog2(MAX_COUNTER_VALUE + 1);
    localparam logic [CW-1:0] C_MAX_M1 = CW'(MAX_COUNTER_VALUE - 1);
    localparam logic [CW-1:0] C_MAX    = CW'(MAX_COUNTER_VALUE);
    localparam logic [CW-1:0] C_HIGH   = CW'(HIGH_COUNTER_VALUE);
    localparam logic [CW-1:0] C_LOW    = CW'(LOW_COUNTER_VALUE);
    localparam logic [CW-1:0] C_MIN    = CW'(MIN_PULSE_VALUE);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;

    logic [2:0]    r_sync;
    logic          r_rise;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_chan;
    logic          r_valid;
    logic          r_err;
    logic          w_level;

`ifdef FAILSAFE_EN
    localparam int TW = $clog2(TIMEOUT_VALUE + 1);
    localparam logic [TW-1:0] C_TMO    = TW'(TIMEOUT_VALUE);
    localparam logic [TW-1:0] C_TMO_M1 = TW'(TIMEOUT_VALUE - 1);
    logic [TW-1:0] r_tmo;
    logic          r_lost;
`endif

    assign w_level = r_sync[2];

    // Synchronizer is deliberately unreset so a pin held high through reset is seen as high.
    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[1:0], i_pwm};
        r_rise <= r_sync[1] & ~r_sync[2];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_SYNC;
            r_cnt   <= '0;
            r_chan  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef FAILSAFE_EN
            r_tmo   <= '0;
            r_lost  <= 1'b0;
`endif
        end else if (!i_en) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
`ifdef FAILSAFE_EN
            if (r_rise) begin
                r_tmo <= '0;
            end else if (r_tmo != C_TMO) begin
                r_tmo <= r_tmo + TW'(1);
                if (r_tmo == C_TMO_M1) begin
                    r_lost <= 1'b1;
                    r_chan <= 1'b0;
                end
            end
`endif
            case (r_state)
                S_SYNC: begin
                    if (!w_level) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (r_rise) begin
                        r_cnt   <= CW'(1);
                        r_state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    // Level going low is the falling edge; robust to edges missed while disabled.
                    if (!w_level) begin
                        r_state <= S_ARMED;
                        if (r_cnt < C_MIN) begin
                            r_err <= 1'b1;
                        end else begin
                            r_valid <= 1'b1;
                            r_err   <= 1'b0;
`ifdef FAILSAFE_EN
                            r_lost  <= 1'b0;
`endif
                            if (r_cnt >= C_HIGH)     r_chan <= 1'b1;
                            else if (r_cnt <= C_LOW) r_chan <= 1'b0;
                        end
                    end else if (r_cnt == C_MAX_M1) begin
                        r_cnt   <= C_MAX;
                        r_err   <= 1'b1;
                        r_state <= S_SYNC;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

    assign o_chan  = r_chan;
    assign o_valid = r_valid;
    assign o_error = r_err;
`ifdef FAILSAFE_EN
    assign o_lost  = r_lost;
`else
    assign o_lost  = 1'b0;
`endif
endmodule

module rc_pwm_demodulator_array #(
    parameter int CHANNELS           = 8,
    parameter int MAX_COUNTER_VALUE  = 2500,
    parameter int HIGH_COUNTER_VALUE = 1800,
    parameter int LOW_COUNTER_VALUE  = 1200,
    parameter int MIN_PULSE_VALUE    = 500,
    parameter int TIMEOUT_VALUE      = 25000
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    rc_pwm_demodulator_array_if.slave     io
);
    localparam int OW = $clog2(CHANNELS + 1);

    logic [CHANNELS-1:0] w_chan;
    logic [CHANNELS-1:0] w_valid;
    logic [CHANNELS-1:0] w_err;
    logic [CHANNELS-1:0] w_lost;
    logic [OW-1:0]       w_ones;
    logic [OW-1:0]       r_ones;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        rc_pwm_channel #(
            .MAX_COUNTER_VALUE  (MAX_COUNTER_VALUE),
            .HIGH_COUNTER_VALUE (HIGH_COUNTER_VALUE),
            .LOW_COUNTER_VALUE  (LOW_COUNTER_VALUE),
            .MIN_PULSE_VALUE    (MIN_PULSE_VALUE),
            .TIMEOUT_VALUE      (TIMEOUT_VALUE)
        ) u_ch (
            .i_clk   (clock_i),
            .i_rst   (reset_i),
            .i_en    (io.enable_i),
            .i_pwm   (io.pwm_i[g]),
            .o_chan  (w_chan[g]),
            .o_valid (w_valid[g]),
            .o_error (w_err[g]),
            .o_lost  (w_lost[g])
        );
    end

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < CHANNELS; i++) w_ones = w_ones + OW'(w_chan[i]);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) r_ones <= '0;
        else         r_ones <= w_ones;
    end

    assign io.channel_o     = w_chan;
    assign io.pulse_valid_o = w_valid;
    assign io.pulse_error_o = w_err;
    assign io.signal_lost_o = w_lost;
    assign io.ones_o        = r_ones;
endmodule

// File: tb/tb_rc_pwm_demodulator_array.sv
// Scoreboard bench for rc_pwm_demodulator_array: directed pulses push expected output
// events; a monitor pops and compares on every strobe / error / loss change.
module tb_rc_pwm_demodulator_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc_pwm_demodulator_array_if #(.CHANNELS(8)) bus ();

    rc_pwm_demodulator_array #(.CHANNELS(8)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .io      (bus)
    );

    typedef struct {
        logic [7:0] vld;
        logic [7:0] chan;
        logic [7:0] err;
        logic [7:0] lost;
        logic [3:0] ones;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_events = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: an output event is any strobe or any change of error/loss flags.
    logic [7:0] prev_err  = '0;
    logic [7:0] prev_lost = '0;
    logic       ones_pend = 1'b0;
    logic [3:0] ones_exp  = '0;
    always @(negedge clk) begin
        if (ones_pend) begin
            check("ones_o", 32'(bus.ones_o), 32'(ones_exp));
            ones_pend = 1'b0;
        end
        if (!rst && (bus.pulse_valid_o != 8'h0 || bus.pulse_error_o != prev_err ||
                     bus.signal_lost_o != prev_lost)) begin
            n_events++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: valid=%0h err=%0h lost=%0h", bus.pulse_valid_o,
                         bus.pulse_error_o, bus.signal_lost_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_valid_o", 32'(bus.pulse_valid_o), 32'(e.vld));
                check("channel_o", 32'(bus.channel_o), 32'(e.chan));
                check("pulse_error_o", 32'(bus.pulse_error_o), 32'(e.err));
                check("signal_lost_o", 32'(bus.signal_lost_o), 32'(e.lost));
                ones_exp  = e.ones;
                ones_pend = 1'b1;
            end
        end
        prev_err  = bus.pulse_error_o;
        prev_lost = bus.signal_lost_o;
    end

    task automatic expect_ev(input logic [7:0] vld, chan, err, lost, input logic [3:0] ones);
        exp_t e;
        e.vld = vld; e.chan = chan; e.err = err; e.lost = lost; e.ones = ones;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events pending, expected 0", name, q.size());
            q.delete();
        end
        repeat (50) @(negedge clk);
    endtask

    // High for exactly 'width' rising edges; optional disable window starting after 500 edges.
    task automatic pulse(input logic [7:0] mask, input int width, input int dis);
        @(negedge clk);
        bus.pwm_i = bus.pwm_i | mask;
        if (dis > 0) begin
            repeat (500) @(negedge clk);
            bus.enable_i = 1'b0;
            repeat (dis) @(negedge clk);
            bus.enable_i = 1'b1;
            repeat (width - 500 - dis) @(negedge clk);
        end else begin
            repeat (width) @(negedge clk);
        end
        bus.pwm_i = bus.pwm_i & ~mask;
    endtask

    task automatic vec(input string name, input logic [7:0] mask, input int width, input int dis,
                       input logic [7:0] vld, chan, err, lost, input logic [3:0] ones);
        expect_ev(vld, chan, err, lost, ones);
        pulse(mask, width, dis);
        wait_drain(300, name);
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable_i = 1'b1;
        bus.pwm_i    = 8'h04;          // ch2 high across reset release
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_channel_o", 32'(bus.channel_o), 32'h0);
        check("rst_pulse_valid_o", 32'(bus.pulse_valid_o), 32'h0);
        check("rst_pulse_error_o", 32'(bus.pulse_error_o), 32'h0);
        check("rst_signal_lost_o", 32'(bus.signal_lost_o), 32'h0);
        check("rst_ones_o", 32'(bus.ones_o), 32'h0);
        repeat (100) @(negedge clk);
        bus.pwm_i = 8'h00;
        repeat (50) @(negedge clk);
        check("partial_pulse_ignored", 32'(n_events), 32'h0);

        //   name             mask   width  dis   vld    chan   err    lost   ones
        vec("ch0_1900",      8'h01, 1900,  0,   8'h01, 8'h01, 8'h00, 8'h00, 4'd1);
        vec("ch0_1500_hold", 8'h01, 1500,  0,   8'h01, 8'h01, 8'h00, 8'h00, 4'd1);
        vec("ch0_1100_off",  8'h01, 1100,  0,   8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        vec("ch0_1800_on",   8'h01, 1800,  0,   8'h01, 8'h01, 8'h00, 8'h00, 4'd1);
        vec("ch0_1799_hold", 8'h01, 1799,  0,   8'h01, 8'h01, 8'h00, 8'h00, 4'd1);
        vec("ch0_1200_off",  8'h01, 1200,  0,   8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        vec("ch0_1201_hold", 8'h01, 1201,  0,   8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        vec("all_1900",      8'hFF, 1900,  0,   8'hFF, 8'hFF, 8'h00, 8'h00, 4'd8);
        vec("all_en_freeze", 8'hFF, 2000,  900, 8'hFF, 8'h00, 8'h00, 8'h00, 4'd0);
        vec("ch3_glitch300", 8'h08, 300,   0,   8'h00, 8'h00, 8'h08, 8'h00, 4'd0);
        vec("ch3_500_ok",    8'h08, 500,   0,   8'h08, 8'h00, 8'h00, 8'h00, 4'd0);
        vec("ch3_glitch499", 8'h08, 499,   0,   8'h00, 8'h00, 8'h08, 8'h00, 4'd0);
        vec("ch3_1900",      8'h08, 1900,  0,   8'h08, 8'h08, 8'h00, 8'h00, 4'd1);
        vec("ch5_1100",      8'h20, 1100,  0,   8'h20, 8'h08, 8'h00, 8'h00, 4'd1);
        vec("ch5_stuck",     8'h20, 3000,  0,   8'h00, 8'h08, 8'h20, 8'h00, 4'd1);
        vec("ch5_1900",      8'h20, 1900,  0,   8'h20, 8'h28, 8'h00, 8'h00, 4'd2);
        vec("ch5_2499",      8'h20, 2499,  0,   8'h20, 8'h28, 8'h00, 8'h00, 4'd2);
        vec("ch5_2500_err",  8'h20, 2500,  0,   8'h00, 8'h28, 8'h20, 8'h00, 4'd2);
        vec("ch5_1100_off",  8'h20, 1100,  0,   8'h20, 8'h08, 8'h00, 8'h00, 4'd1);
`ifdef FAILSAFE_EN
        vec("fs_all_1900",   8'hFF, 1900,  0,   8'hFF, 8'hFF, 8'h00, 8'h00, 4'd8);
        expect_ev(8'h00, 8'h00, 8'h00, 8'hFF, 4'd0);
        wait_drain(26000, "fs_lost");
        vec("fs_ch1_1900",   8'h02, 1900,  0,   8'h02, 8'h02, 8'h00, 8'hFD, 4'd1);
`endif
        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
